// File: rtl/e203_ifu_flush_rsp.sv
// IFU end of the commit flush interface: single-outstanding sequential fetcher
// that redirects to the flush adder result and answers the WFI halt handshake.
module e203_ifu_flush_rsp #(
  parameter int                 PC_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RST_PC  = PC_SIZE'(32'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_ack,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack,
  output logic               fch_cmd_valid,
  input  logic               fch_cmd_ready,
  output logic [PC_SIZE-1:0] fch_cmd_addr,
  input  logic               fch_rsp_valid,
  output logic               fch_rsp_ready,
  input  logic [31:0]        fch_rsp_instr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [PC_SIZE-1:0] ir_pc,
  output logic [31:0]        ir_instr
);

  typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;

  state_t             state_reg, state_next;
  logic [PC_SIZE-1:0] pc_reg;
  logic [PC_SIZE-1:0] cmd_pc_reg;
  logic               out_reg;
  logic               drop_reg;

  logic               cmd_hs;
  logic               rsp_hs;
  logic               rsp_discard;
  logic [PC_SIZE-1:0] flush_target;

  // Carry out of the flush adder is intentionally lost: targets wrap.
  assign flush_target   = pipe_flush_add_op1 + pipe_flush_add_op2;

  assign pipe_flush_ack = pipe_flush_req;
  assign ifu_halt_ack   = (state_reg == HALTED);

  assign fch_cmd_valid  = (state_reg == RUN) & ~out_reg & ~pipe_flush_req;
  assign fch_cmd_addr   = pc_reg;
  assign fch_rsp_ready  = drop_reg | pipe_flush_req | ~ir_valid | ir_ready;

  assign cmd_hs         = fch_cmd_valid & fch_cmd_ready;
  assign rsp_hs         = fch_rsp_valid & fch_rsp_ready;
  assign rsp_discard    = drop_reg | pipe_flush_req;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (ifu_halt_req) state_next = HALTING;
      HALTING: begin
        if (!ifu_halt_req)            state_next = RUN;
        else if (!out_reg || rsp_hs)  state_next = HALTED;
      end
      HALTED:  if (!ifu_halt_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      pc_reg     <= RST_PC;
      cmd_pc_reg <= '0;
      out_reg    <= 1'b0;
      drop_reg   <= 1'b0;
      ir_valid   <= 1'b0;
      ir_pc      <= '0;
      ir_instr   <= '0;
    end else begin
      state_reg <= state_next;

      if (pipe_flush_req) begin
        pc_reg <= flush_target;
      end else if (cmd_hs) begin
        pc_reg <= pc_reg + PC_SIZE'(4);
      end

      if (cmd_hs) begin
        cmd_pc_reg <= pc_reg;
      end

      if (cmd_hs) begin
        out_reg <= 1'b1;
      end else if (rsp_hs) begin
        out_reg <= 1'b0;
      end

      // A response already on the bus during a flush is discarded right
      // away, so only a still-pending fetch needs a deferred drop.
      if (pipe_flush_req) begin
        drop_reg <= out_reg & ~fch_rsp_valid;
      end else if (rsp_hs) begin
        drop_reg <= 1'b0;
      end

      if (pipe_flush_req) begin
        ir_valid <= 1'b0;
      end else if (rsp_hs && !rsp_discard) begin
        ir_valid <= 1'b1;
        ir_pc    <= cmd_pc_reg;
        ir_instr <= fch_rsp_instr;
      end else if (ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/e203_ifu_flush_rsp.md
# e203_ifu_flush_rsp

Responder end of the commit flush interface, located in the IFU. It accepts `pipe_flush_req` with the two adder operands and computes the new fetch PC with its own adder. It drains or discards the single outstanding instruction fetch and restarts sequential fetch at the flush target. It also serves as the responder for the WFI IFU-halt handshake.

## Interface
Parameters:
- `PC_SIZE`, 32, width of the PC and fetch address.
- `RST_PC`, 32'h8000_0000, fetch PC after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pipe_flush_req`  in  1  flush request from commit.
- `pipe_flush_add_op1`  in  PC_SIZE  flush adder operand 1.
- `pipe_flush_add_op2`  in  PC_SIZE  flush adder operand 2.
- `pipe_flush_ack`  out  1  flush accepted.
- `ifu_halt_req`  in  1  WFI halt request.
- `ifu_halt_ack`  out  1  IFU halted, with no fetch outstanding.
- `fch_cmd_valid`  out  1  fetch command valid.
- `fch_cmd_ready`  in  1  fetch command accepted.
- `fch_cmd_addr`  out  PC_SIZE  fetch address.
- `fch_rsp_valid`  in  1  fetch response valid.
- `fch_rsp_ready`  out  1  fetch response accepted.
- `fch_rsp_instr`  in  32  fetched instruction.
- `ir_valid`  out  1  instruction register valid.
- `ir_ready`  in  1  downstream consumes IR.
- `ir_pc`  out  PC_SIZE  PC of the IR instruction.
- `ir_instr`  out  32  IR instruction.

## Operation
- Registers:
  - `pc_r`: next fetch PC.
  - `cmd_pc_r`: PC of the outstanding command.
  - `out_r`: one fetch outstanding.
  - `drop_r`: discard the next response.
  - IR: `ir_valid`, `ir_pc`, `ir_instr`.
  - state `{RUN, HALTING, HALTED}`.
- At most one fetch is outstanding.
- Command channel:
  - `fch_cmd_valid = (state==RUN) & ~out_r & ~pipe_flush_req`.
  - `fch_cmd_addr = pc_r`.
  - On command handshake: `out_r<=1`, `cmd_pc_r<=pc_r`, `pc_r<=pc_r+4` (modulo 2^PC_SIZE).
- Response channel:
  - `fch_rsp_ready = drop_r | pipe_flush_req | ~ir_valid | ir_ready`.
  - On response handshake: `out_r<=0`.
  - If `drop_r` or `pipe_flush_req` is high, the response is discarded and `drop_r<=0`.
  - Otherwise the IR loads `{1, cmd_pc_r, fch_rsp_instr}`.
- IR consume: `ir_valid & ir_ready` with no new load clears `ir_valid`.
- Flush:
  - `pipe_flush_ack = pipe_flush_req`; flush is always accepted in the same cycle, in any state.
  - On acceptance: `pc_r <= (op1+op2)[PC_SIZE-1:0]`, carry discarded.
  - On acceptance: `ir_valid<=0`.
  - On acceptance: `drop_r <= out_r & ~fch_rsp_valid`.
  - State is unchanged by a flush.
- Halt FSM:
  - RUN -> HALTING when `ifu_halt_req`.
  - HALTING -> HALTED when `out_r==0`, or when the response handshake occurs this cycle.
  - HALTED -> RUN when `~ifu_halt_req`.
  - HALTING -> RUN when `ifu_halt_req` drops before the drain completes.
  - `ifu_halt_ack = (state==HALTED)`, a registered output.
  - The IR is not cleared by halt.
- Reset values: `pc_r=RST_PC`, `out_r=0`, `drop_r=0`, `ir_valid=0`, `ir_pc=0`, `ir_instr=0`, state RUN.
  - Outputs after reset: `ifu_halt_ack=0`, `fch_cmd_valid=1` (unless a flush is requested).

## Timing
- Flush acceptance is combinational: `pipe_flush_ack` follows `pipe_flush_req` with zero cycles of latency.
- The first command to the flush target is issued the cycle after the flush, provided `out_r` is clear then.
- If a fetch is outstanding, its response is dropped. The target command follows the cycle after that response.
- Flush and response in the same cycle: the response is dropped, `drop_r` stays 0, and the target command issues the next cycle.
- Flush and command handshake never coincide, because `cmd_valid` is gated by the flush.
- Back-to-back flushes: the last one wins; `pc_r` takes each sum in turn.
- Sequential throughput is one instruction per two cycles (command, then response). The response may return no earlier than the cycle after its command.
- Halt ack asserts one cycle after the drain completes. It deasserts one cycle after `ifu_halt_req` falls.
- Synchronous reset mid-fetch: the outstanding flag is cleared. The environment must also reset the memory side.

## Test plan
- Reset, then `fch_cmd_ready=1`, responses 1 cycle later with instructions 0x13, 0x93:
  - IR PCs are 0x8000_0000 then 0x8000_0004.
  - `pc_r` is 0x8000_0008.
- Flush with op1=0x8000_0100, op2=0xFFFF_FFF0 while idle:
  - `ack=1` the same cycle.
  - The next command address is 0x8000_00F0.
- Flush while a fetch is outstanding:
  - The late response (0xDEAD) is dropped and `ir_valid` stays 0.
  - The following command goes to the target, and its response loads the IR with the target PC.
- Flush in the same cycle as the response: the response is discarded and no drop is pending afterwards.
- Halt while a fetch is outstanding, response delayed 3 cycles:
  - No new commands are issued.
  - `ifu_halt_ack` rises 1 cycle after the response.
  - When `ifu_halt_req` is released, the ack falls and fetch resumes at the sequential PC.
- Flush with op1=0xFFFF_FFFC, op2=8: the target wraps to 0x0000_0004.
